ndp_layer_sequencer: RTL

//  Single-clock control core for the NDP datapath: ingests A/B tiles from AXI4-Stream into an N-bank

---
 rtl/ndp_pkg.sv | 23 ++
 rtl/ndp_bank_tracker.sv | 85 ++++++++
 rtl/ndp_layer_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ndp_pkg.sv
// Shared types and sizing helpers for the NDP layer sequencer slice.
package ndp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PAD       = 3'd2,
    ST_WAIT_BANK = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_CAPTURE   = 3'd5,
    ST_SEND      = 3'd6
  } state_e;

  localparam int SP_ADDR_W = 8;
  localparam int BANK_W    = 2;
  localparam int MAX_BANKS = 4;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ndp_bank_tracker.sv
// Full/last bookkeeping for the scratch-pad banks; producer fills at wr_ptr, consumer drains at rd_ptr.
module ndp_bank_tracker
  import ndp_pkg::*;
#(
  parameter int NUM_BANKS = 2
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic              set_last_i,
  input  logic              release_i,
  output logic [BANK_W-1:0] wr_ptr_o,
  output logic [BANK_W-1:0] rd_ptr_o,
  output logic              wr_free_o,
  output logic              nxt_free_o,
  output logic              rd_avail_o,
  output logic              rd_last_o
);

  logic [MAX_BANKS-1:0] full_q;
  logic [MAX_BANKS-1:0] last_q;
  logic [BANK_W-1:0]    wr_ptr_q;
  logic [BANK_W-1:0]    rd_ptr_q;
  logic [BANK_W-1:0]    pend_bank_q;
  logic                 pend_q;
  logic                 pend_last_q;
  logic                 collide;

  function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] p);
    return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign collide = set_i && release_i && (wr_ptr_q == rd_ptr_q);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      full_q      <= '0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_bank_q <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else if (flush_i) begin
      full_q      <= '0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      if (pend_q) begin
        full_q[pend_bank_q] <= 1'b1;
        last_q[pend_bank_q] <= pend_last_q;
        pend_q              <= 1'b0;
      end
      if (release_i) begin
        full_q[rd_ptr_q] <= 1'b0;
        last_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= bank_inc(rd_ptr_q);
      end
      // A fill landing on the bank being released is deferred one cycle so the release wins.
      if (set_i) begin
        wr_ptr_q <= bank_inc(wr_ptr_q);
        if (collide) begin
          pend_q      <= 1'b1;
          pend_bank_q <= wr_ptr_q;
          pend_last_q <= set_last_i;
        end else begin
          full_q[wr_ptr_q] <= 1'b1;
          last_q[wr_ptr_q] <= set_last_i;
        end
      end
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign wr_free_o  = !full_q[wr_ptr_q] && !(pend_q && (pend_bank_q == wr_ptr_q));
  assign nxt_free_o = !full_q[bank_inc(wr_ptr_q)];
  assign rd_avail_o = full_q[rd_ptr_q];
  assign rd_last_o  = last_q[rd_ptr_q];

endmodule

// File: rtl/ndp_layer_sequencer.sv
// NDP control core: stream tiles into scratch-pad banks, feed NDP_unit on a ce cadence,
// chain layers through the result register and stream the final result out.
module ndp_layer_sequencer
  import ndp_pkg::*;
#(
  parameter int AXIS_W     = 32,
  parameter int A_WORDS    = 2,
  parameter int B_WORDS    = 32,
  parameter int NUM_BANKS  = 2,
  parameter int MAX_LAYERS = 8,
  parameter int RES_WORDS  = 128,
  parameter int CE_RATIO   = 25,
  parameter int KEY_W      = 17,
  localparam int RES_AW    = clog2_min1(RES_WORDS)
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  cfg_start,
  input  logic [3:0]            cfg_layers,
  input  logic [MAX_LAYERS-1:0] cfg_relu_mask,
  output logic                  busy,
  output logic                  err_short,
  input  logic [AXIS_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  sp_wen,
  output logic [1:0]            sp_wbank,
  output logic [7:0]            sp_waddr,
  output logic [AXIS_W-1:0]     sp_wdata,
  output logic [1:0]            sp_rbank,
  output logic                  ndp_clr,
  output logic                  ndp_feed,
  output logic                  ndp_src_reg,
  output logic [KEY_W-1:0]      ndp_key,
  output logic                  ndp_in_done,
  input  logic                  ndp_calc_done,
  output logic                  relu_en,
  output logic                  res_capture,
  output logic [RES_AW-1:0]     res_raddr,
  input  logic [AXIS_W-1:0]     res_rdata,
  output logic [AXIS_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [2:0]            dbg_state
);

  // Both streams use AXI4-Stream rules: a beat moves on a cycle with tvalid && tready;
  // the source holds tdata/tlast steady while tvalid is high and tready is low.

  localparam int CE_W = clog2_min1(CE_RATIO);
  localparam int LAY_W = clog2_min1(MAX_LAYERS);
  localparam logic [SP_ADDR_W-1:0] LAST_ADDR = SP_ADDR_W'(A_WORDS + B_WORDS - 1);
  localparam logic [SP_ADDR_W-1:0] REG_START = SP_ADDR_W'(A_WORDS);

  state_e                  state_q, state_d;
  logic [CE_W-1:0]         ce_cnt_q;
  logic                    ce;
  logic [SP_ADDR_W-1:0]    waddr_q, waddr_d, tile_start;
  logic [LAY_W-1:0]        layer_q, layer_d;
  logic [3:0]              layers_q, layers_d;
  logic [MAX_LAYERS-1:0]   mask_q, mask_d;
  logic                    err_q, err_d;
  logic [RES_AW-1:0]       raddr_q, raddr_d;
  logic                    is_last_layer, start_layer;
  logic                    clr_pend_q, clr_q, feed_q, feed_last_q, in_done_q;
  logic [KEY_W-1:0]        key_q;
  logic [BANK_W-1:0]       rbank_q;
  logic                    bk_flush, bk_set, bk_set_last, bk_release;
  logic [BANK_W-1:0]       wr_ptr, rd_ptr;
  logic                    wr_free, nxt_free, rd_avail, rd_last;

  assign ce = (ce_cnt_q == CE_W'(CE_RATIO - 1));

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) ce_cnt_q <= '0;
    else              ce_cnt_q <= ce ? '0 : ce_cnt_q + 1'b1;
  end

  ndp_bank_tracker #(.NUM_BANKS(NUM_BANKS)) u_banks (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .flush_i     (bk_flush),
    .set_i       (bk_set),
    .set_last_i  (bk_set_last),
    .release_i   (bk_release),
    .wr_ptr_o    (wr_ptr),
    .rd_ptr_o    (rd_ptr),
    .wr_free_o   (wr_free),
    .nxt_free_o  (nxt_free),
    .rd_avail_o  (rd_avail),
    .rd_last_o   (rd_last)
  );

  assign tile_start    = (layer_q == '0) ? '0 : REG_START;
  assign is_last_layer = ((4'(layer_q) + 4'd1) >= layers_q);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q  <= ST_IDLE;
      waddr_q  <= '0;
      layer_q  <= '0;
      layers_q <= 4'd1;
      mask_q   <= '0;
      err_q    <= 1'b0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      layer_q  <= layer_d;
      layers_q <= layers_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      raddr_q  <= raddr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    layer_d       = layer_q;
    layers_d      = layers_q;
    mask_d        = mask_q;
    err_d         = err_q;
    raddr_d       = raddr_q;
    start_layer   = 1'b0;
    bk_flush      = 1'b0;
    bk_set        = 1'b0;
    bk_set_last   = 1'b0;
    s_axis_tready = 1'b0;
    sp_wen        = 1'b0;
    sp_wdata      = '0;
    res_capture   = 1'b0;
    m_axis_tvalid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d     = ST_LOAD;
          layer_d     = '0;
          mask_d      = cfg_relu_mask;
          err_d       = 1'b0;
          waddr_d     = '0;
          start_layer = 1'b1;
          bk_flush    = 1'b1;
          if (cfg_layers == 4'd0)                  layers_d = 4'd1;
          else if (cfg_layers > 4'(MAX_LAYERS))    layers_d = 4'(MAX_LAYERS);
          else                                     layers_d = cfg_layers;
        end
      end
      ST_LOAD: begin
        s_axis_tready = wr_free;
        if (s_axis_tvalid && wr_free) begin
          sp_wen   = 1'b1;
          sp_wdata = s_axis_tdata;
          if (waddr_q == LAST_ADDR) begin
            bk_set      = 1'b1;
            bk_set_last = s_axis_tlast;
            waddr_d     = tile_start;
            if (s_axis_tlast)  state_d = ST_DRAIN;
            else if (!nxt_free) state_d = ST_WAIT_BANK;
          end else begin
            waddr_d = waddr_q + 1'b1;
            if (s_axis_tlast) begin
              err_d   = 1'b1;
              state_d = ST_PAD;
            end
          end
        end
      end
      // Zero-fill the rest of a short tile, then treat it as the layer's last tile.
      ST_PAD: begin
        sp_wen = 1'b1;
        if (waddr_q == LAST_ADDR) begin
          bk_set      = 1'b1;
          bk_set_last = 1'b1;
          waddr_d     = tile_start;
          state_d     = ST_DRAIN;
        end else begin
          waddr_d = waddr_q + 1'b1;
        end
      end
      ST_WAIT_BANK: begin
        if (wr_free) state_d = ST_LOAD;
      end
      ST_DRAIN: begin
        if (ce && in_done_q && !clr_pend_q && ndp_calc_done) begin
          if (is_last_layer) begin
            state_d = ST_SEND;
            raddr_d = '0;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end
      ST_CAPTURE: begin
        res_capture = 1'b1;
        layer_d     = layer_q + 1'b1;
        waddr_d     = REG_START;
        start_layer = 1'b1;
        state_d     = ST_LOAD;
      end
      ST_SEND: begin
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) begin
          if (raddr_q == RES_AW'(RES_WORDS - 1)) begin
            state_d = ST_IDLE;
            raddr_d = '0;
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Compute side: everything here moves only on ce. A feed holds its bank for one
  // ce period and frees it at the ce that ends the feed.
  assign bk_release = ce && !clr_pend_q && feed_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      clr_pend_q  <= 1'b0;
      clr_q       <= 1'b1;
      feed_q      <= 1'b0;
      feed_last_q <= 1'b0;
      in_done_q   <= 1'b0;
      key_q       <= '0;
      rbank_q     <= '0;
    end else begin
      if (ce) begin
        if (clr_pend_q) begin
          clr_q      <= 1'b1;
          feed_q     <= 1'b0;
          key_q      <= '0;
          in_done_q  <= 1'b0;
          clr_pend_q <= 1'b0;
        end else begin
          clr_q <= 1'b0;
          if (feed_q) begin
            feed_q <= 1'b0;
            if (feed_last_q) in_done_q <= 1'b1;
          end else if (rd_avail && !in_done_q) begin
            feed_q      <= 1'b1;
            feed_last_q <= rd_last;
            key_q       <= key_q + 1'b1;
            rbank_q     <= rd_ptr;
          end
        end
      end
      if (start_layer) clr_pend_q <= 1'b1;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign err_short    = err_q;
  assign sp_wbank     = wr_ptr;
  assign sp_waddr     = waddr_q;
  assign sp_rbank     = rbank_q;
  assign ndp_clr      = clr_q;
  assign ndp_feed     = feed_q;
  assign ndp_src_reg  = (layer_q != '0);
  assign ndp_key      = key_q;
  assign ndp_in_done  = in_done_q;
  assign relu_en      = mask_q[layer_q];
  assign res_raddr    = raddr_q;
  assign m_axis_tdata = res_rdata;
  assign m_axis_tlast = (state_q == ST_SEND) && (raddr_q == RES_AW'(RES_WORDS - 1));
  assign dbg_state    = state_q;

endmodule
